// File: rtl/dmem_pkg.sv
// Shared types for the data-memory controller: funct3 encodings, FSM states, word geometry.
package dmem_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } state_e;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store strobe/replication and load extension for a 32-bit word,
// plus misalignment and illegal-funct3 detection.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic                    we,
  input  logic [2:0]              funct3,
  input  logic [1:0]              addr_lo,
  input  logic [31:0]             wdata,
  input  logic [31:0]             rword,
  output logic [WORD_BYTES-1:0]   strb,
  output logic [31:0]             wdata_rep,
  output logic [31:0]             rdata,
  output logic                    misalign,
  output logic                    illegal
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign shifted = rword >> {addr_lo, 3'b000};
  assign byte_v  = shifted[7:0];
  assign half_v  = addr_lo[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    strb      = '0;
    wdata_rep = wdata;
    rdata     = '0;
    misalign  = 1'b0;
    illegal   = 1'b0;
    case (funct3_e'(funct3))
      F3_B: begin
        strb      = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata     = {{24{byte_v[7]}}, byte_v};
      end
      F3_H: begin
        strb      = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        rdata     = {{16{half_v[15]}}, half_v};
        misalign  = addr_lo[0];
      end
      F3_W: begin
        strb     = 4'b1111;
        rdata    = rword;
        misalign = |addr_lo;
      end
      // Unsigned variants exist only as loads; strb stays 0 for stores.
      F3_BU: begin
        rdata   = {24'h0, byte_v};
        illegal = we;
      end
      F3_HU: begin
        rdata    = {16'h0, half_v};
        misalign = addr_lo[0];
        illegal  = we;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: valid/ready request/response, wait states, byte-lane stores, extended loads.
// Optional macro DMEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into error responses.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 32,
  parameter int WAIT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);

  generate
    if (DATA_W != 32) begin : g_bad_data_w
      $error("dmem_ctrl: DATA_W must be 32");
    end
    if (WAIT_CYC < 0 || WAIT_CYC > 15) begin : g_bad_wait
      $error("dmem_ctrl: WAIT_CYC must be 0..15");
    end
  endgenerate

  state_e                state, state_nxt;
  logic [3:0]            cnt;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     rword_q;
  logic [DATA_W-1:0]     mem [DEPTH];
  logic [WORD_BYTES-1:0] strb;
  logic [DATA_W-1:0]     wdata_rep, rdata_ext;
  logic                  misalign, illegal, err, accept;
  logic [ADDR_W-3:0]     idx;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign idx       = addr_q[ADDR_W-1:2];

  dmem_lane_align u_align (
    .we       (we_q),
    .funct3   (f3_q),
    .addr_lo  (addr_q[1:0]),
    .wdata    (wdata_q),
    .rword    (rword_q),
    .strb     (strb),
    .wdata_rep(wdata_rep),
    .rdata    (rdata_ext),
    .misalign (misalign),
    .illegal  (illegal)
  );

`ifdef DMEM_MISALIGN_TRAP_EN
  assign err = illegal | misalign;
`else
  assign err = illegal;
  logic unused_misalign;
  assign unused_misalign = misalign;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (WAIT_CYC > 0) ? WAIT : ACCESS;
      WAIT:    if (cnt == 4'd0) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    if (resp_valid && resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      f3_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        cnt     <= 4'(WAIT_CYC - 1);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      // First RESP cycle extracts from the word read in ACCESS; then hold until taken.
      if (state == RESP && !resp_valid) begin
        resp_valid <= 1'b1;
        resp_err   <= err;
        resp_rdata <= (we_q || err) ? '0 : rdata_ext;
      end else if (resp_valid && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

  // Array has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (state == ACCESS) begin
      if (we_q && !err) begin
        for (int i = 0; i < WORD_BYTES; i++)
          if (strb[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
      rword_q <= mem[idx];
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl; three instances with WAIT_CYC = 0, 3, 2.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we [3];
  logic [2:0]  req_funct3 [3];
  logic [8:0]  req_addr [3];
  logic [31:0] req_wdata [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [31:0] resp_rdata [3];
  logic        resp_err [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_ctrl #(.ADDR_W(9), .DATA_W(32), .WAIT_CYC(g == 0 ? 0 : (g == 1 ? 3 : 2))) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_funct3(req_funct3[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .resp_valid(resp_valid[g]),
      .resp_ready(resp_ready[g]),
      .resp_rdata(resp_rdata[g]),
      .resp_err  (resp_err[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, req);
    end
  endtask

  // One full transaction on instance d; checks data, error, latency and return to idle.
  task automatic xact(input string tag, input int d, input logic we, input logic [2:0] f3,
                      input logic [8:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    int lat;
    @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = we; req_funct3[d] = f3;
    req_addr[d] = a; req_wdata[d] = wd;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!resp_valid[d] && lat < 40);
    chk({tag, ".valid"}, 32'(resp_valid[d]), 32'd1);
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".rdata"}, resp_rdata[d], exp_rd);
    chk({tag, ".err"}, 32'(resp_err[d]), 32'(exp_err));
    @(negedge clk);
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    resp_ready[d] = 1'b0;
    chk({tag, ".idle"}, {30'd0, req_ready[d], resp_valid[d]}, 32'b10);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_funct3[i] = '0;
      req_addr[i] = '0; req_wdata[i] = '0; resp_ready[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst.ready", 32'(req_ready[i]), 32'd1);
      chk("rst.valid", 32'(resp_valid[i]), 32'd0);
      chk("rst.rdata", resp_rdata[i], 32'd0);
      chk("rst.err", 32'(resp_err[i]), 32'd0);
    end
    @(negedge clk) rst_n = 1'b1;

    // Basic word store/load.
    xact("sw10", 0, 1'b1, 3'b010, 9'h010, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    xact("lw10", 0, 1'b0, 3'b010, 9'h010, 32'h0, 32'hDEADBEEF, 1'b0, 2);

    // Byte store into lane 1, signed/unsigned byte loads, word read-back.
    xact("sb11", 0, 1'b1, 3'b000, 9'h011, 32'h00000080, 32'h0, 1'b0, 2);
    xact("lb11", 0, 1'b0, 3'b000, 9'h011, 32'h0, 32'hFFFFFF80, 1'b0, 2);
    xact("lbu11", 0, 1'b0, 3'b100, 9'h011, 32'h0, 32'h00000080, 1'b0, 2);
    xact("lw10b", 0, 1'b0, 3'b010, 9'h010, 32'h0, 32'hDEAD80EF, 1'b0, 2);

    // Upper half store and half loads.
    xact("sh22", 0, 1'b1, 3'b001, 9'h022, 32'h00008001, 32'h0, 1'b0, 2);
    xact("lh22", 0, 1'b0, 3'b001, 9'h022, 32'h0, 32'hFFFF8001, 1'b0, 2);
    xact("lhu22", 0, 1'b0, 3'b101, 9'h022, 32'h0, 32'h00008001, 1'b0, 2);

    // Illegal funct3 for load and store; store must not touch the array.
    xact("ld011", 0, 1'b0, 3'b011, 9'h010, 32'h0, 32'h0, 1'b1, 2);
    xact("st011", 0, 1'b1, 3'b011, 9'h010, 32'hFFFFFFFF, 32'h0, 1'b1, 2);
    xact("sbu", 0, 1'b1, 3'b100, 9'h010, 32'hFFFFFFFF, 32'h0, 1'b1, 2);
    xact("lw10c", 0, 1'b0, 3'b010, 9'h010, 32'h0, 32'hDEAD80EF, 1'b0, 2);
    xact("lb13", 0, 1'b0, 3'b000, 9'h013, 32'h0, 32'hFFFFFFDE, 1'b0, 2);
    xact("lhu12", 0, 1'b0, 3'b101, 9'h012, 32'h0, 32'h0000DEAD, 1'b0, 2);
`ifdef DMEM_MISALIGN_TRAP_EN
    xact("lw13", 0, 1'b0, 3'b010, 9'h013, 32'h0, 32'h0, 1'b1, 2);
    xact("sw13", 0, 1'b1, 3'b010, 9'h013, 32'h12121212, 32'h0, 1'b1, 2);
    xact("lw10d", 0, 1'b0, 3'b010, 9'h010, 32'h0, 32'hDEAD80EF, 1'b0, 2);
`else
    xact("lw13", 0, 1'b0, 3'b010, 9'h013, 32'h0, 32'hDEAD80EF, 1'b0, 2);
    xact("lh23", 0, 1'b0, 3'b001, 9'h023, 32'h0, 32'hFFFF8001, 1'b0, 2);
`endif

    // Wait states plus back-pressure on the response.
    xact("sw40", 1, 1'b1, 3'b010, 9'h040, 32'h12345678, 32'h0, 1'b0, 5);
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_funct3[1] = 3'b010; req_addr[1] = 9'h040;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    chk("bp.busy", 32'(req_ready[1]), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("bp.early", 32'(resp_valid[1]), 32'd0);
    @(posedge clk); #1;
    chk("bp.valid5", 32'(resp_valid[1]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("bp.hold", {resp_valid[1], req_ready[1], resp_err[1]}, 3'b100);
      chk("bp.data", resp_rdata[1], 32'h12345678);
    end
    @(negedge clk) resp_ready[1] = 1'b1;
    @(posedge clk); #1;
    resp_ready[1] = 1'b0;
    chk("bp.done", {30'd0, req_ready[1], resp_valid[1]}, 32'b10);

    // Reset during WAIT aborts a store.
    xact("sw30", 2, 1'b1, 3'b010, 9'h030, 32'h11111111, 32'h0, 1'b0, 4);
    @(negedge clk);
    req_valid[2] = 1'b1; req_we[2] = 1'b1; req_funct3[2] = 3'b010;
    req_addr[2] = 9'h030; req_wdata[2] = 32'h22222222;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    chk("ab.busy", 32'(req_ready[2]), 32'd0);
    rst_n = 1'b0;
    #2;
    chk("ab.idle", {30'd0, req_ready[2], resp_valid[2]}, 32'b10);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    chk("ab.rdata", resp_rdata[2], 32'h0);
    xact("lw30", 2, 1'b0, 3'b010, 9'h030, 32'h0, 32'h11111111, 1'b0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
